// File: rtl/konix_input_pkg.sv
// Shared bit maps, SOCD mode/flag types and the per-axis SOCD resolver used by
// the MiSTer-to-Konix joystick mapper.
package konix_input_pkg;

  // MiSTer joystick vector bit positions (active-high)
  localparam int JB_R    = 0;
  localparam int JB_L    = 1;
  localparam int JB_D    = 2;
  localparam int JB_U    = 3;
  localparam int JB_F1   = 4;
  localparam int JB_F2   = 5;
  localparam int JB_PEDL = 6;
  localparam int JB_PEDR = 7;

  // Konix port byte bit positions (active-low)
  localparam int KB_PEDL = 0;
  localparam int KB_PEDR = 1;
  localparam int KB_F1   = 2;
  localparam int KB_F2   = 3;
  localparam int KB_L    = 4;
  localparam int KB_R    = 5;
  localparam int KB_U    = 6;
  localparam int KB_D    = 7;

  localparam logic [7:0] KONIX_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    SOCD_PASS        = 2'd0,
    SOCD_NEUTRAL     = 2'd1,
    SOCD_LAST        = 2'd2,
    SOCD_NEUTRAL_ALT = 2'd3
  } socd_mode_e;

  typedef enum logic [1:0] {
    LAST_NONE   = 2'd0,
    LAST_FIRST  = 2'd1,
    LAST_SECOND = 2'd2
  } socd_last_e;

  typedef struct packed {
    logic       first;
    logic       second;
    socd_last_e flag;
  } socd_axis_t;

  // Resolves one axis: 'first'/'second' are the two opposing directions, the
  // *_q inputs their previous stage-1 values, 'flag' the last-pressed memory.
  function automatic socd_axis_t socd_axis(input socd_mode_e mode,
                                           input logic first, input logic second,
                                           input logic first_q, input logic second_q,
                                           input socd_last_e flag);
    socd_axis_t r;
    logic rise_f;
    logic rise_s;
    rise_f   = first & ~first_q;
    rise_s   = second & ~second_q;
    r.first  = first;
    r.second = second;
    r.flag   = flag;
    if (rise_f && !rise_s) r.flag = LAST_FIRST;
    else if (rise_s && !rise_f) r.flag = LAST_SECOND;
    if (first && second && mode != SOCD_PASS) begin
      r.first  = 1'b0;
      r.second = 1'b0;
      // A simultaneous rise stays neutral even if an older flag is stored.
      if (mode == SOCD_LAST && !(rise_f && rise_s)) begin
        r.first  = (r.flag == LAST_FIRST);
        r.second = (r.flag == LAST_SECOND);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/konix_autofire.sv
// Autofire for one fire button: toggles a phase every 'period' held cycles,
// starting asserted on press; passes the button through when disabled.
module konix_autofire
  import konix_input_pkg::*;
#(
  parameter int AF_W = 20
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            btn,
  input  logic            en,
  input  logic [AF_W-1:0] period,
  output logic            q
);

  logic            btn_q;
  logic            en_q;
  logic [AF_W-1:0] period_q;
  logic [AF_W-1:0] cnt;
  logic [AF_W-1:0] cnt_d;
  logic            phase;
  logic            phase_d;
  logic            active;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    phase_d = phase;
    cnt_d   = cnt;
    active  = en && (period != '0);
    if (!btn) begin
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (!btn_q) begin
      phase_d = 1'b1;
      cnt_d   = '0;
    end else if (!active || en != en_q || period != period_q) begin
      cnt_d = '0;
    end else if (cnt == period - AF_W'(1)) begin
      phase_d = ~phase;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt + AF_W'(1);
    end
    q = btn && (!active || phase_d);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      btn_q    <= 1'b0;
      en_q     <= 1'b0;
      period_q <= '0;
      cnt      <= '0;
      phase    <= 1'b0;
    end else begin
      btn_q    <= btn;
      en_q     <= en;
      period_q <= period;
      cnt      <= cnt_d;
      phase    <= phase_d;
    end
  end

endmodule

// File: rtl/konix_joy_mapper.sv
// Maps N active-high MiSTer joysticks onto N active-low Konix port bytes with
// clone mode, SOCD cleaning, autofire and optional pedals; 2-cycle latency.
module konix_joy_mapper
  import konix_input_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int JOY_W     = 8,
  parameter int AF_W      = 20,
  parameter int PEDAL_EN  = 0
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [NUM_PORTS*JOY_W-1:0] joy_in,
  input  logic                       clone_mode,
  input  logic [1:0]                 socd_mode,
  input  logic [NUM_PORTS*2-1:0]     af_en,
  input  logic [AF_W-1:0]            af_period,
  output logic [NUM_PORTS*8-1:0]     joy_out
);

  localparam int CW     = (JOY_W < 8) ? JOY_W : 8;
  localparam bit PEDALS = (PEDAL_EN != 0);

  socd_mode_e socd_q;
  logic [7:0] raw0;

  always_comb begin
    raw0         = '0;
    raw0[CW-1:0] = joy_in[CW-1:0];
  end

  // Mode travels through stage 1 alongside the data it applies to.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) socd_q <= SOCD_PASS;
    else          socd_q <= socd_mode_e'(socd_mode);
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [7:0] raw;
    logic [7:0] s1;
    logic [3:0] dir_q;
    socd_last_e flag_lr;
    socd_last_e flag_ud;
    socd_axis_t lr;
    socd_axis_t ud;
    logic       f1;
    logic       f2;
    logic [7:0] held;
    logic [7:0] out_q;

    always_comb begin
      raw         = '0;
      raw[CW-1:0] = joy_in[k*JOY_W +: CW];
    end

    always_ff @(posedge clk_sys) begin
      if (!reset_n) s1 <= '0;
      else          s1 <= clone_mode ? raw0 : raw;
    end

    assign lr = socd_axis(socd_q, s1[JB_L], s1[JB_R], dir_q[JB_L], dir_q[JB_R], flag_lr);
    assign ud = socd_axis(socd_q, s1[JB_U], s1[JB_D], dir_q[JB_U], dir_q[JB_D], flag_ud);

    konix_autofire #(.AF_W(AF_W)) u_af_f1 (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .btn     (s1[JB_F1]),
      .en      (af_en[2*k]),
      .period  (af_period),
      .q       (f1)
    );

    konix_autofire #(.AF_W(AF_W)) u_af_f2 (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .btn     (s1[JB_F2]),
      .en      (af_en[2*k+1]),
      .period  (af_period),
      .q       (f2)
    );

    always_comb begin
      held          = '0;
      held[KB_L]    = lr.first;
      held[KB_R]    = lr.second;
      held[KB_U]    = ud.first;
      held[KB_D]    = ud.second;
      held[KB_F1]   = f1;
      held[KB_F2]   = f2;
      held[KB_PEDL] = PEDALS ? s1[JB_PEDL] : 1'b0;
      held[KB_PEDR] = PEDALS ? s1[JB_PEDR] : 1'b0;
    end

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        dir_q   <= '0;
        flag_lr <= LAST_NONE;
        flag_ud <= LAST_NONE;
        out_q   <= KONIX_IDLE;
      end else begin
        dir_q   <= s1[JB_U:JB_R];
        flag_lr <= lr.flag;
        flag_ud <= ud.flag;
        out_q   <= ~held;
      end
    end

    assign joy_out[k*8 +: 8] = out_q;
  end

endmodule

// File: doc/konix_joy_mapper.md
Name: konix_joy_mapper

Overview:
- Parametrised successor to the fixed joystick mapping in the Konix top level.
- Converts N MiSTer joystick vectors (active-high) into N Konix joystick port bytes (active-low) for m_konix.
- Adds an independent/clone port mode, SOCD cleaning, per-button autofire with a configurable period, and optional pedal-from-button emulation.
- Sits between hps_io and m_konix in the clk_sys domain.

Parameters:
- NUM_PORTS, 2, number of Konix joystick ports produced.
- JOY_W, 8, width of each MiSTer joystick vector.
- AF_W, 20, width of the autofire half-period counter.
- PEDAL_EN, 0, 1 = joystick bits [7:6] drive the pedal bits; 0 = pedal bits are held 2'b11.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- joy_in  in  NUM_PORTS*JOY_W  MiSTer joysticks, channel k at [k*JOY_W +: JOY_W]. Bits: [0]R [1]L [2]D [3]U [4]F1 [5]F2 [6]PedL [7]PedR.
- clone_mode  in  1  1 = every port is sourced from channel 0 (legacy behaviour); 0 = port k is sourced from channel k.
- socd_mode  in  2  0 pass-through, 1 opposite directions give neutral, 2 last pressed wins, 3 treated as 1.
- af_en  in  NUM_PORTS*2  per-port autofire enable; bit 2k = F1, bit 2k+1 = F2.
- af_period  in  AF_W  autofire half-period in clk_sys cycles; 0 disables autofire globally.
- joy_out  out  NUM_PORTS*8  Konix ports, active-low. Bits: [7]D [6]U [5]R [4]L [3]F2 [2]F1 [1]PedR [0]PedL.

Behaviour:
- Reset: all internal registers cleared; joy_out = all ones (nothing pressed) on the cycle after reset_n is sampled low and while it stays low.
- Pipeline:
  - Stage 1 registers the selected source vector per port.
  - Stage 2 applies SOCD and autofire and registers joy_out, inverted.
  - Total latency joy_in to joy_out is 2 cycles.
  - clone_mode and socd_mode take effect with the same 2-cycle latency.
- SOCD is evaluated separately per axis (L/R and U/D), per port.
  - Mode 1: both pressed → both released at the output.
  - Mode 2: one last-pressed flag per axis. It is set to the direction that had a 0→1 stage-1 transition. If both rise in the same cycle, the result is neutral and the flag is unchanged. While both are held, only the flagged direction is output. When one is released, the other passes through.
  - The flag resets to "none", which gives neutral.
- Autofire, per port and per fire button, with af_en set and af_period ≠ 0:
  - Each button has its own counter and phase register.
  - On a press (0→1 at stage 1): phase = 1 (asserted) and counter = 0.
  - While held: counter increments. When counter == af_period − 1, phase toggles and counter returns to 0. Output = phase.
  - On release: output is deasserted at once, counter = 0, phase = 0.
  - af_en or af_period changing mid-hold: the counter restarts at 0 and phase is left as is.
  - af_en clear or af_period = 0: the button passes through unchanged.
- Pedals: when PEDAL_EN=1, bits [1:0] = ~{PedR, PedL}; otherwise 2'b11. SOCD and autofire are never applied to pedals.
- Unused bits: joy_in bits above [7] are ignored when JOY_W > 8. When JOY_W < 8, the missing bits read as 0.
- Reset mid-hold: all counters, phases and SOCD flags clear. After reset_n rises, a still-held button counts as a fresh press on the first stage-1 sample.

Decomposition:
- Shared package konix_input_pkg holds:
  - MiSTer bit-index constants (JB_R…JB_PEDR).
  - Konix bit-index constants (KB_D…KB_PEDL).
  - The socd_mode enum.
  - The idle value 8'hFF.
- One sub-module, konix_autofire: one button, with ports clk_sys, reset_n, btn, en, period, q. It is instantiated 2*NUM_PORTS times.
- SOCD logic and port muxing stay inline, inside a generate loop over the ports.

Test Plan:
- Reset with clone_mode=1, joy_in ch0=8'h01 held → joy_out=16'hFFFF during reset; 2 cycles after release both ports = 8'hDF.
- clone_mode=0, ch0=8'h10, ch1=8'h08 → port0=8'hFB, port1=8'hBF; latency exactly 2 cycles.
- socd_mode=1, ch0 L+R (8'h03) → 8'hFF. socd_mode=2: L at t0, then R added at t5 → R-only 8'hDF; release R → 8'hEF. L and R rising in the same cycle → 8'hFF.
- af_en[0]=1, af_period=4, hold F1 for 20 cycles → F1 output bit low for 4 cycles, high for 4, repeating, starting the first output cycle. Release mid-phase → bit high on the next output cycle.
- af_period=0 with af_en=1, hold F2 → bit 3 low continuously. Switching af_period to 3 mid-hold → counter restarts and toggling begins 3 cycles later.
- PEDAL_EN=1, ch0=8'hC0 → 8'hFC. PEDAL_EN=0 with the same input → 8'hFF. reset_n pulsed low for 1 cycle mid-autofire → output 8'hFF during reset, and the held button restarts in the asserted phase.
